// File: rtl/ysyx_220066_div_issue_pkg.sv
// Purpose: shared widths, ALUctr bit positions and FSM encoding for the divider issue block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ysyx_220066_div_issue_pkg;

    // Operand/result width and destination register index width.
    localparam int XLEN = 64;
    localparam int RD_W = 5;

    // ALUctr bit positions: bit0 selects unsigned, bit1 selects remainder.
    localparam int ALU_UNSIGNED = 0;
    localparam int ALU_REM      = 1;

    // FSM encoding.
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_ISSUE_ENC = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
    localparam logic [2:0] ST_DONE_ENC  = 3'd3;
    localparam logic [2:0] ST_DRAIN_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_DONE  = ST_DONE_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_e;

endpackage

// File: rtl/ysyx_220066_div_issue_if.sv
// Purpose: request/response bundle between the issue block and the radix-2 divider.
// Latency: n/a (wires only).
// Backpressure: request side is valid/ready; response side is a one-cycle pulse with no backpressure.
//
// Signals:
//   div_in_valid / div_in_ready : request handshake (issuer -> divider)
//   div_src1, div_src2          : dividend / divisor, held stable while div_in_valid=1
//   div_is_w, div_aluctr        : 32-bit variant flag, {rem, unsigned} control
//   div_out_valid, div_result   : one-cycle result pulse and data (divider -> issuer)
interface ysyx_220066_div_issue_if;
    import ysyx_220066_div_issue_pkg::*;

    logic            div_in_valid;
    logic            div_in_ready;
    logic [XLEN-1:0] div_src1;
    logic [XLEN-1:0] div_src2;
    logic            div_is_w;
    logic [1:0]      div_aluctr;
    logic            div_out_valid;
    logic [XLEN-1:0] div_result;

    // Issuer side.
    modport master (
        output div_in_valid,
        output div_src1,
        output div_src2,
        output div_is_w,
        output div_aluctr,
        input  div_in_ready,
        input  div_out_valid,
        input  div_result
    );

    // Divider side.
    modport slave (
        input  div_in_valid,
        input  div_src1,
        input  div_src2,
        input  div_is_w,
        input  div_aluctr,
        output div_in_ready,
        output div_out_valid,
        output div_result
    );

endinterface

// File: rtl/ysyx_220066_div_special.sv
// Purpose: detects divide-by-zero and signed overflow and forms the RV64 fast-path result.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   src1, src2  : dividend / divisor as offered by execute (upper half ignored for W ops)
//   is_w        : 32-bit variant, results sign-extended from bit 31
//   aluctr      : bit ALU_UNSIGNED = unsigned, bit ALU_REM = remainder
//   div_zero    : effective divisor is zero
//   sgn_ovf     : signed most-negative / -1 case
//   fast_result : architectural result when either flag is set, zero otherwise
module ysyx_220066_div_special
    import ysyx_220066_div_issue_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            is_w,
    input  logic [1:0]      aluctr,
    output logic            div_zero,
    output logic            sgn_ovf,
    output logic [XLEN-1:0] fast_result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] dividend_ext;
    logic            dividend_min;
    logic            divisor_m1;
    logic            is_rem;

    // For W ops the dividend that appears in the result is the sign-extended low word.
    assign dividend_ext = is_w ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;

    assign div_zero     = is_w ? (src2[31:0] == 32'd0) : (src2 == '0);
    assign dividend_min = is_w ? (src1[31:0] == 32'h8000_0000) : (src1 == MOST_NEG);
    assign divisor_m1   = is_w ? (src2[31:0] == 32'hFFFF_FFFF) : (src2 == '1);
    assign sgn_ovf      = !aluctr[ALU_UNSIGNED] && dividend_min && divisor_m1;
    assign is_rem       = aluctr[ALU_REM];

    // Divide-by-zero and overflow are mutually exclusive (divisor 0 vs -1).
    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            // Quotient is all-ones (already sign-extended for W), remainder is the dividend.
            fast_result = is_rem ? dividend_ext : '1;
        end else if (sgn_ovf) begin
            // Quotient is the dividend itself, remainder is zero.
            fast_result = is_rem ? '0 : dividend_ext;
        end
    end

endmodule

// File: rtl/ysyx_220066_div_issue.sv
// Purpose: accepts one DIV/REM(+U,+W) op, issues it to the divider and holds the result for writeback.
// Latency: fast path (div-by-zero / overflow) wb_valid 1 cycle after accept; otherwise divider latency + 2.
// Backpressure: ex_ready only in IDLE; result held in DONE until wb_ready; divider response never stalled.
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   ex_valid/ex_ready, ex_src1/2,
//   ex_is_w, ex_aluctr, ex_rd          : op offered by execute
//   flush                              : kills any in-flight op
//   div_if (master)                    : divider request/response bundle
//   wb_valid/wb_ready, wb_rd, wb_data  : writeback result handshake
module ysyx_220066_div_issue
    import ysyx_220066_div_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [XLEN-1:0]      ex_src1,
    input  logic [XLEN-1:0]      ex_src2,
    input  logic                 ex_is_w,
    input  logic [1:0]           ex_aluctr,
    input  logic [RD_W-1:0]      ex_rd,

    input  logic                 flush,

    ysyx_220066_div_issue_if.master div_if,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [RD_W-1:0]      wb_rd,
    output logic [XLEN-1:0]      wb_data
);

    state_e          state_q,   state_d;
    logic [XLEN-1:0] src1_q,    src1_d;
    logic [XLEN-1:0] src2_q,    src2_d;
    logic            is_w_q,    is_w_d;
    logic [1:0]      aluctr_q,  aluctr_d;
    logic [RD_W-1:0] rd_q,      rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            accept;
    logic            div_hs;
    logic            wb_hs;
    logic            div_zero;
    logic            sgn_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] result_fixed;

    ysyx_220066_div_special u_special (
        .src1        (ex_src1),
        .src2        (ex_src2),
        .is_w        (ex_is_w),
        .aluctr      (ex_aluctr),
        .div_zero    (div_zero),
        .sgn_ovf     (sgn_ovf),
        .fast_result (fast_result)
    );

    assign fast_hit = div_zero || sgn_ovf;

    assign ex_ready = (state_q == ST_IDLE);
    assign accept   = ex_valid && ex_ready && !flush;

    // Operands come straight from the capture registers, which only change on accept,
    // so they are stable for the whole ISSUE window.
    assign div_if.div_in_valid = (state_q == ST_ISSUE);
    assign div_if.div_src1     = src1_q;
    assign div_if.div_src2     = src2_q;
    assign div_if.div_is_w     = is_w_q;
    assign div_if.div_aluctr   = aluctr_q;
    assign div_hs              = div_if.div_in_valid && div_if.div_in_ready;

    assign wb_valid = (state_q == ST_DONE);
    assign wb_rd    = rd_q;
    assign wb_data  = wb_data_q;
    assign wb_hs    = wb_valid && wb_ready;

    // The divider returns the raw 32-bit result for W ops; the unsigned W variants
    // come back zero-extended, so the sign extension is always applied here.
    assign result_fixed = is_w_q ? {{(XLEN-32){div_if.div_result[31]}}, div_if.div_result[31:0]}
                                 : div_if.div_result;

    always_comb begin
        state_d   = state_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        is_w_d    = is_w_q;
        aluctr_d  = aluctr_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    src1_d   = ex_src1;
                    src2_d   = ex_src2;
                    is_w_d   = ex_is_w;
                    aluctr_d = ex_aluctr;
                    rd_d     = ex_rd;
                    if (fast_hit) begin
                        state_d   = ST_DONE;
                        wb_data_d = fast_result;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                // Once the divider has taken the op it cannot be aborted, so a flush
                // coinciding with the handshake has to wait out the result.
                if (flush) begin
                    state_d = div_hs ? ST_DRAIN : ST_IDLE;
                end else if (div_hs) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (div_if.div_out_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        wb_data_d = result_fixed;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                if (flush || wb_hs) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Flush is irrelevant here: the result is discarded either way.
                if (div_if.div_out_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            is_w_q    <= 1'b0;
            aluctr_q  <= 2'b00;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            is_w_q    <= is_w_d;
            aluctr_q  <= aluctr_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // A result pulse is only legal while an issued op is outstanding.
    a_out_valid_window: assert property (
        @(posedge clk) disable iff (!rst_n)
        div_if.div_out_valid |-> (state_q == ST_WAIT || state_q == ST_DRAIN)
    );

endmodule

// File: tb/tb_ysyx_220066_div_issue.sv
// Purpose: directed bench for the divider issue block with a behavioural divider and a result scoreboard.
// Latency: divider model latency set per step via div_lat.
// Backpressure: wb_ready and the divider's in_ready are driven from the step sequence.
module tb_ysyx_220066_div_issue;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_src1;
    logic [63:0] ex_src2;
    logic        ex_is_w;
    logic [1:0]  ex_aluctr;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    ysyx_220066_div_issue_if dif ();

    ysyx_220066_div_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_src1   (ex_src1),
        .ex_src2   (ex_src2),
        .ex_is_w   (ex_is_w),
        .ex_aluctr (ex_aluctr),
        .ex_rd     (ex_rd),
        .flush     (flush),
        .div_if    (dif),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    int hs_cnt    = 0;
    int dv_hs_cnt = 0;
    int div_iv_cnt = 0;
    int wbv_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural divider ----------------
    int          div_lat = 4;
    logic        dv_rdy;
    logic        busy_q;
    int          cnt_q;
    logic [63:0] pend_q;

    function automatic logic [63:0] raw_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input logic [1:0] c);
        logic [31:0] r32;
        logic [63:0] r64;
        r64 = '0;
        if (w) begin
            if (c[0]) r32 = c[1] ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
            else      r32 = c[1] ? ($signed(a[31:0]) % $signed(b[31:0]))
                                 : ($signed(a[31:0]) / $signed(b[31:0]));
            r64 = {32'h0, r32};
        end else begin
            if (c[0]) r64 = c[1] ? (a % b) : (a / b);
            else      r64 = c[1] ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
        end
        return r64;
    endfunction

    assign dif.div_in_ready = dv_rdy && !busy_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q            <= 1'b0;
            cnt_q             <= 0;
            pend_q            <= '0;
            dif.div_out_valid <= 1'b0;
            dif.div_result    <= '0;
        end else begin
            dif.div_out_valid <= 1'b0;
            if (busy_q) begin
                if (cnt_q <= 1) begin
                    dif.div_out_valid <= 1'b1;
                    dif.div_result    <= pend_q;
                    busy_q            <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1;
                end
            end else if (dif.div_in_valid && dif.div_in_ready) begin
                busy_q <= 1'b1;
                cnt_q  <= div_lat;
                pend_q <= raw_div(dif.div_src1, dif.div_src2, dif.div_is_w, dif.div_aluctr);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        if (rst_n) begin
            if (dif.div_in_valid && dif.div_in_ready) dv_hs_cnt++;
            if (dif.div_in_valid) div_iv_cnt++;
            if (wb_valid) wbv_cnt++;
            if (wb_valid && wb_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $error("FAIL sb_unexpected_wb observed_rd=%0d observed_data=%h expected=none",
                           wb_rd, wb_data);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("wb_data", wb_data, sb_e.data);
                    check("wb_rd", 64'(wb_rd), 64'(sb_e.rd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- step helpers ----------------
    task automatic issue_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                            input logic [1:0] c, input logic [4:0] rd);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_src1   = a;
        ex_src2   = b;
        ex_is_w   = w;
        ex_aluctr = c;
        ex_rd     = rd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ex_ready && !flush) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("accept", 64'(got), 64'd1);
    endtask

    task automatic wait_wb(input string tag);
        int h0;
        h0 = hs_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hs_cnt != h0) break;
        end
        repeat (2) @(negedge clk);
        check(tag, 64'(hs_cnt - h0), 64'd1);
    endtask

    task automatic wait_div_hs();
        int d0;
        d0 = dv_hs_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dv_hs_cnt != d0) break;
        end
        check("div_handshake", 64'(dv_hs_cnt - d0), 64'd1);
    endtask

    task automatic normal_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic w, input logic [1:0] c, input logic [4:0] rd,
                             input logic [63:0] exp);
        sb_q.push_back('{rd: rd, data: exp});
        issue_op(a, b, w, c, rd);
        @(negedge clk);
        check({tag, "_in_valid"}, 64'(dif.div_in_valid), 64'd1);
        wait_wb({tag, "_hs"});
    endtask

    task automatic fast_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic w, input logic [1:0] c, input logic [4:0] rd,
                           input logic [63:0] exp);
        int iv0;
        iv0 = div_iv_cnt;
        sb_q.push_back('{rd: rd, data: exp});
        issue_op(a, b, w, c, rd);
        @(negedge clk);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
        check({tag, "_wb_data"}, wb_data, exp);
        wait_wb({tag, "_hs"});
        check({tag, "_no_issue"}, 64'(div_iv_cnt - iv0), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int h0;
        int v0;
        int d0;
        logic seen;

        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        ex_src1   = '0;
        ex_src2   = '0;
        ex_is_w   = 1'b0;
        ex_aluctr = 2'b00;
        ex_rd     = '0;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        dv_rdy    = 1'b1;

        // Reset values.
        #3;
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_in_valid", 64'(dif.div_in_valid), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_div_src1", dif.div_src1, 64'd0);
        #19 rst_n = 1'b1;

        // Divider path, signed and unsigned, 64-bit and W.
        normal_op("div_100_7", 64'd100, 64'd7, 1'b0, 2'b00, 5'd3, 64'd14);
        normal_op("rem_100_7", 64'd100, 64'd7, 1'b0, 2'b10, 5'd4, 64'd2);
        normal_op("divuw_ffff", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 2'b01, 5'd11,
                  64'hFFFF_FFFF_FFFF_FFFF);
        normal_op("div_neg", 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 2'b00, 5'd12,
                  64'hFFFF_FFFF_FFFF_FFFA);
        normal_op("rem_neg", 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 2'b10, 5'd13,
                  64'hFFFF_FFFF_FFFF_FFFE);
        normal_op("remuw", 64'h1234_5678_FFFF_FFFF, 64'h10, 1'b1, 2'b11, 5'd14, 64'h0000_0000_0000_000F);
        normal_op("divw_neg", 64'h1234_5678_FFFF_FFF8, 64'd2, 1'b1, 2'b00, 5'd15,
                  64'hFFFF_FFFF_FFFF_FFFC);
        normal_op("divu_min_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b01,
                  5'd16, 64'd0);

        // Local fast path: divide-by-zero and signed overflow.
        fast_op("div_by0", 64'd5, 64'd0, 1'b0, 2'b00, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
        fast_op("rem_by0", 64'd5, 64'd0, 1'b0, 2'b10, 5'd18, 64'd5);
        fast_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, 5'd19,
                64'h8000_0000_0000_0000);
        fast_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10, 5'd20,
                64'd0);
        fast_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'b00, 5'd21,
                64'hFFFF_FFFF_8000_0000);
        fast_op("divw_by0_hi", 64'd5, 64'h0000_0001_0000_0000, 1'b1, 2'b00, 5'd22,
                64'hFFFF_FFFF_FFFF_FFFF);
        fast_op("remw_by0_hi", 64'd7, 64'h0000_0001_0000_0000, 1'b1, 2'b10, 5'd23, 64'd7);

        // Flush in ISSUE before the divider takes the op; operands held meanwhile.
        dv_rdy = 1'b0;
        d0 = dv_hs_cnt;
        issue_op(64'd8, 64'd2, 1'b0, 2'b00, 5'd10);
        @(negedge clk);
        check("issue_in_valid", 64'(dif.div_in_valid), 64'd1);
        check("issue_src1", dif.div_src1, 64'd8);
        @(negedge clk);
        check("issue_src1_hold", dif.div_src1, 64'd8);
        check("issue_src2_hold", dif.div_src2, 64'd2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("issue_flush_in_valid", 64'(dif.div_in_valid), 64'd0);
        check("issue_flush_ex_ready", 64'(ex_ready), 64'd1);
        check("issue_flush_no_hs", 64'(dv_hs_cnt - d0), 64'd0);
        dv_rdy = 1'b1;

        // Flush in WAIT: drain the divider, then accept the op offered meanwhile.
        div_lat = 20;
        h0 = hs_cnt;
        issue_op(64'd8, 64'd2, 1'b0, 2'b00, 5'd5);
        wait_div_hs();
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        ex_valid  = 1'b1;
        ex_src1   = 64'd9;
        ex_src2   = 64'd3;
        ex_is_w   = 1'b0;
        ex_aluctr = 2'b00;
        ex_rd     = 5'd6;
        sb_q.push_back('{rd: 5'd6, data: 64'd3});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.div_out_valid) begin
                seen = 1'b1;
                break;
            end
            check("drain_ex_ready", 64'(ex_ready), 64'd0);
            check("drain_wb_valid", 64'(wb_valid), 64'd0);
        end
        check("drain_out_valid", 64'(seen), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ex_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("drain_back_idle", 64'(seen), 64'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("after_drain_in_valid", 64'(dif.div_in_valid), 64'd1);
        wait_wb("after_drain_hs");
        check("drain_total_hs", 64'(hs_cnt - h0), 64'd1);
        div_lat = 4;

        // Writeback backpressure: result held stable in DONE.
        wb_ready = 1'b0;
        sb_q.push_back('{rd: 5'd7, data: 64'd10});
        issue_op(64'd50, 64'd5, 1'b0, 2'b00, 5'd7);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_reach_done", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_wb_valid", 64'(wb_valid), 64'd1);
            check("hold_wb_data", wb_data, 64'd10);
            check("hold_wb_rd", 64'(wb_rd), 64'd7);
        end
        wb_ready = 1'b1;
        wait_wb("hold_hs");

        // Flush in DONE: wb_valid drops without a handshake.
        wb_ready = 1'b0;
        h0 = hs_cnt;
        issue_op(64'd1, 64'd0, 1'b0, 2'b00, 5'd8);
        @(negedge clk);
        check("done_flush_pre_valid", 64'(wb_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("done_flush_wb_valid", 64'(wb_valid), 64'd0);
        check("done_flush_ex_ready", 64'(ex_ready), 64'd1);
        check("done_flush_no_hs", 64'(hs_cnt - h0), 64'd0);
        wb_ready = 1'b1;

        // Asynchronous reset in the middle of WAIT.
        div_lat = 20;
        h0 = hs_cnt;
        issue_op(64'd100, 64'd7, 1'b0, 2'b00, 5'd9);
        wait_div_hs();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ex_ready", 64'(ex_ready), 64'd1);
        check("arst_wb_valid", 64'(wb_valid), 64'd0);
        check("arst_in_valid", 64'(dif.div_in_valid), 64'd0);
        check("arst_wb_data", wb_data, 64'd0);
        check("arst_wb_rd", 64'(wb_rd), 64'd0);
        check("arst_div_src1", dif.div_src1, 64'd0);
        #10 rst_n = 1'b1;
        v0 = wbv_cnt;
        repeat (30) @(negedge clk);
        check("arst_no_wb_valid", 64'(wbv_cnt - v0), 64'd0);
        check("arst_no_hs", 64'(hs_cnt - h0), 64'd0);
        div_lat = 4;

        // Recovery after reset.
        normal_op("post_rst_div", 64'd9, 64'd3, 1'b0, 2'b00, 5'd24, 64'd3);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
